// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key scheduler: forward-expands the cipher key to
// round 10, then streams round keys 10..0 back out on a valid/ready port.
module aes_inv_key_sched #(
   parameter bit EQ_INV = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_key_valid,
   output logic         o_key_ready,
   input  logic [0:127] i_key,
   output logic         o_rk_valid,
   input  logic         i_rk_ready,
   output logic [0:127] o_rk,
   output logic [3:0]   o_rk_round,
   output logic         o_rk_last,
   output logic         o_busy
);

   typedef enum logic [1:0] {IDLE, FWD, OUT} state_t;

   state_t       state;
   logic [127:0] wk;
   logic [3:0]   rc_idx;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // Inverse as a^254 by repeated squaring, then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
               ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] imc_col(input logic [31:0] c);
      logic [7:0] s [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         s[i]  = c[31-8*i -: 8];
         x2    = xt(s[i]);
         x4    = xt(x2);
         x8    = xt(x4);
         m9[i] = x8 ^ s[i];
         mb[i] = x8 ^ x2 ^ s[i];
         md[i] = x8 ^ x4 ^ s[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   logic [31:0]  w0, w1, w2, w3, v3;
   logic [31:0]  sw_in, sw_out, t;
   logic [7:0]   rc;
   logic [3:0]   round_nx;
   logic [127:0] fwd_key, back_key, rk_nx;

   assign {w0, w1, w2, w3} = wk;
   assign v3 = w3 ^ w2;

   // One SubWord instance serves both directions.
   assign sw_in  = (state == OUT) ? v3 : w3;
   assign sw_out = {sbox(sw_in[23:16]), sbox(sw_in[15:8]),
                    sbox(sw_in[7:0]),   sbox(sw_in[31:24])};
   assign rc     = rcon((state == OUT) ? o_rk_round : rc_idx);
   assign t      = w0 ^ sw_out ^ {rc, 24'h0};

   assign fwd_key  = {t, w1 ^ t, w2 ^ w1 ^ t, w3 ^ w2 ^ w1 ^ t};
   assign back_key = {t, w1 ^ w0, w2 ^ w1, v3};
   assign round_nx = o_rk_round - 4'd1;

   assign rk_nx = (EQ_INV && round_nx != 4'd0)
                ? {imc_col(back_key[127:96]), imc_col(back_key[95:64]),
                   imc_col(back_key[63:32]),  imc_col(back_key[31:0])}
                : back_key;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         wk          <= '0;
         rc_idx      <= '0;
         o_rk        <= '0;
         o_rk_round  <= '0;
         o_rk_valid  <= 1'b0;
         o_rk_last   <= 1'b0;
         o_busy      <= 1'b0;
         o_key_ready <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               o_key_ready <= 1'b1;
               if (i_key_valid && o_key_ready) begin
                  wk          <= i_key;
                  rc_idx      <= 4'd1;
                  state       <= FWD;
                  o_busy      <= 1'b1;
                  o_key_ready <= 1'b0;
               end
            end
            FWD: begin
               if (rc_idx == 4'd11) begin
                  state      <= OUT;
                  o_rk       <= wk;
                  o_rk_round <= 4'd10;
                  o_rk_valid <= 1'b1;
                  o_rk_last  <= 1'b0;
               end else begin
                  wk     <= fwd_key;
                  rc_idx <= rc_idx + 4'd1;
               end
            end
            OUT: begin
               if (i_rk_ready) begin
                  if (o_rk_round == 4'd0) begin
                     state       <= IDLE;
                     o_rk_valid  <= 1'b0;
                     o_rk_last   <= 1'b0;
                     o_busy      <= 1'b0;
                     o_key_ready <= 1'b1;
                  end else begin
                     wk         <= back_key;
                     o_rk       <= rk_nx;
                     o_rk_round <= round_nx;
                     o_rk_last  <= (round_nx == 4'd0);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
